// File: rtl/attn_inst_sequencer.sv
// Instruction sequencer for the fullchip attention datapath: a start pulse plays one full pass of inst words.
// Defining SEQ_READOUT_EN inserts an OUTMEM readout phase between STORE and DONE.
module attn_inst_sequencer #(
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int gap_cycles  = 10,
    parameter int add_w       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic [31:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  phase
);
    localparam int CW = $clog2(4*total_cycle + col + gap_cycles + (1 << add_w) + 4);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_KLOAD   = 4'd1,
        S_KTAIL   = 4'd2,
        S_GAP1    = 4'd3,
        S_EXEC    = 4'd4,
        S_GAP2    = 4'd5,
        S_NORM    = 4'd6,
        S_VLOAD   = 4'd7,
        S_VTAIL   = 4'd8,
        S_GAP3    = 4'd9,
        S_MAC2    = 4'd10,
        S_GAP4    = 4'd11,
        S_STORE   = 4'd12,
        S_READOUT = 4'd13,
        S_DONE    = 4'd14
    } state_e;

    // state_q/cnt_q name the pending step; phase_q names the step currently held in inst.
    state_e        state_q, state_d;
    state_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   inst_q, inst_d;
    logic          done_q, done_d;

    function automatic logic [CW-1:0] step_len(input state_e st);
        case (st)
            S_KLOAD, S_VLOAD:               step_len = CW'(col + 2);
            S_GAP1, S_GAP2, S_GAP3, S_GAP4: step_len = CW'(gap_cycles);
            S_EXEC, S_MAC2:                 step_len = CW'(total_cycle);
            S_NORM:                         step_len = CW'(4 * total_cycle);
            S_STORE:                        step_len = CW'(2 * total_cycle);
            S_READOUT:                      step_len = CW'(total_cycle + 1);
            default:                        step_len = CW'(1);
        endcase
    endfunction

    function automatic state_e next_state(input state_e st);
        case (st)
            S_KLOAD:   next_state = S_KTAIL;
            S_KTAIL:   next_state = S_GAP1;
            S_GAP1:    next_state = S_EXEC;
            S_EXEC:    next_state = S_GAP2;
            S_GAP2:    next_state = S_NORM;
            S_NORM:    next_state = S_VLOAD;
            S_VLOAD:   next_state = S_VTAIL;
            S_VTAIL:   next_state = S_GAP3;
            S_GAP3:    next_state = S_MAC2;
            S_MAC2:    next_state = S_GAP4;
            S_GAP4:    next_state = S_STORE;
`ifdef SEQ_READOUT_EN
            S_STORE:   next_state = S_READOUT;
`else
            S_STORE:   next_state = S_DONE;
`endif
            S_READOUT: next_state = S_DONE;
            default:   next_state = S_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] step_word(input state_e st, input logic [CW-1:0] s);
        logic [add_w-1:0] ld_addr;
        logic [add_w-1:0] s_addr;
        logic [add_w-1:0] n2_addr;
        logic [add_w-1:0] n4_addr;
        step_word = '0;
        ld_addr   = (s < CW'(2)) ? '0 : add_w'(s - 1'b1);
        s_addr    = add_w'(s);
        n2_addr   = add_w'(s >> 1);
        n4_addr   = add_w'(s >> 2);
        case (st)
            S_KLOAD: begin
                step_word[6]          = 1'b1;
                step_word[3]          = (s != '0);
                step_word[12 +: add_w] = ld_addr;
            end
            S_KTAIL: step_word[6] = 1'b1;
            S_EXEC: begin
                step_word[7]          = 1'b1;
                step_word[5]          = 1'b1;
                step_word[12 +: add_w] = s_addr;
            end
            S_NORM: begin
                case (s[1:0])
                    2'd0: step_word[16] = (n4_addr != '0);
                    2'd1: step_word[18] = 1'b1;
                    2'd2: begin
                        step_word[19] = 1'b1;
                        step_word[20] = 1'b1;
                    end
                    default: begin
                        step_word[0]          = 1'b1;
                        step_word[8 +: add_w] = n4_addr;
                    end
                endcase
            end
            S_VLOAD: begin
                step_word[27]          = 1'b1;
                step_word[22]          = (s != '0);
                step_word[12 +: add_w] = ld_addr;
            end
            S_VTAIL: step_word[27] = 1'b1;
            S_MAC2: begin
                step_word[28]         = 1'b1;
                step_word[1]          = 1'b1;
                step_word[8 +: add_w] = s_addr;
            end
            S_STORE: begin
                if (!s[0]) begin
                    step_word[29] = (n2_addr != '0);
                end else begin
                    step_word[30]         = 1'b1;
                    step_word[8 +: add_w] = n2_addr;
                end
            end
            S_READOUT: begin
                step_word[31]         = 1'b1;
                step_word[8 +: add_w] = s_addr;
            end
            default: step_word = '0;
        endcase
    endfunction

    // NOTE: every state register uses non-blocking assignment so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= S_IDLE;
            cnt_q   <= '0;
            inst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        inst_d  = '0;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            phase_d = S_IDLE;
            if (start && !hold) begin
                inst_d  = step_word(S_KLOAD, '0);
                phase_d = S_KLOAD;
                state_d = S_KLOAD;
                cnt_d   = CW'(1);
            end
        end else if (!hold || state_q == S_DONE) begin
            // DONE always issues so a hold there cannot swallow the done pulse.
            inst_d  = step_word(state_q, cnt_q);
            phase_d = state_q;
            done_d  = (state_q == S_DONE);
            if (cnt_q == step_len(state_q) - 1'b1) begin
                state_d = next_state(state_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign inst  = inst_q;
    assign done  = done_q;
    assign phase = phase_q;
    assign busy  = (phase_q != S_IDLE);

endmodule

// File: tb/tb_attn_inst_sequencer.sv
// Self-checking bench for attn_inst_sequencer: fixed-cycle checks plus randomized holds/stray starts against a step-list model.
module tb_attn_inst_sequencer;
    localparam int COL = 8;
    localparam int TC  = 8;
    localparam int GAP = 10;
`ifdef SEQ_READOUT_EN
    localparam int DONE_CYC = 136;
`else
    localparam int DONE_CYC = 127;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        hold;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  phase;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] steps[$];

    attn_inst_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .hold (hold),
        .inst (inst),
        .busy (busy),
        .done (done),
        .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_q(input int a);
        return 32'(a & 15) << 12;
    endfunction

    function automatic logic [31:0] addr_p(input int a);
        return 32'(a & 15) << 8;
    endfunction

    task automatic add_gap();
        for (int i = 0; i < GAP; i++) steps.push_back(32'h0);
    endtask

    // Ordered list of every issued word of a pass, DONE excluded.
    task automatic build_model();
        steps.delete();
        for (int s = 0; s < COL + 2; s++)
            steps.push_back(32'h40 | ((s >= 1) ? 32'h8 : 32'h0) | addr_q((s < 2) ? 0 : s - 1));
        steps.push_back(32'h40);
        add_gap();
        for (int s = 0; s < TC; s++) steps.push_back(32'hA0 | addr_q(s));
        add_gap();
        for (int n = 0; n < TC; n++) begin
            steps.push_back((n != 0) ? 32'h0001_0000 : 32'h0);
            steps.push_back(32'h0004_0000);
            steps.push_back(32'h0018_0000);
            steps.push_back(32'h1 | addr_p(n));
        end
        for (int s = 0; s < COL + 2; s++)
            steps.push_back(32'h0800_0000 | ((s >= 1) ? 32'h0040_0000 : 32'h0) | addr_q((s < 2) ? 0 : s - 1));
        steps.push_back(32'h0800_0000);
        add_gap();
        for (int s = 0; s < TC; s++) steps.push_back(32'h1000_0002 | addr_p(s));
        add_gap();
        for (int n = 0; n < TC; n++) begin
            steps.push_back((n != 0) ? 32'h2000_0000 : 32'h0);
            steps.push_back(32'h4000_0000 | addr_p(n));
        end
`ifdef SEQ_READOUT_EN
        for (int s = 0; s <= TC; s++) steps.push_back(32'h8000_0000 | addr_p(s));
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        #2;
        n_total++;
        if (inst !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || phase !== 4'd0)
            $display("FAIL reset_state: inst=%h busy=%b done=%b phase=%0d, want all 0", inst, busy, done, phase);
        else n_pass++;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        n_total++;
        if (inst !== 32'h0 || busy !== 1'b0)
            $display("FAIL reset_holds_idle: inst=%h busy=%b, want 0/0", inst, busy);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        logic [31:0] obs[200];
        logic        ob[200];
        logic        od[200];
        start = 1'b1;
        hold  = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            obs[c] = inst;
            ob[c]  = busy;
            od[c]  = done;
        end
        n_total++; if (obs[1]  !== 32'h0000_0040) $display("FAIL nom_c1: got %h want 00000040", obs[1]);  else n_pass++;
        n_total++; if (obs[2]  !== 32'h0000_0048) $display("FAIL nom_c2: got %h want 00000048", obs[2]);  else n_pass++;
        n_total++; if (obs[3]  !== 32'h0000_1048) $display("FAIL nom_c3: got %h want 00001048", obs[3]);  else n_pass++;
        n_total++; if (obs[10] !== 32'h0000_8048) $display("FAIL nom_c10: got %h want 00008048", obs[10]); else n_pass++;
        n_total++; if (obs[11] !== 32'h0000_0040) $display("FAIL nom_c11: got %h want 00000040", obs[11]); else n_pass++;
        n_total++; if (obs[25] !== 32'h0000_30A0) $display("FAIL exec_s3: got %h want 000030a0", obs[25]); else n_pass++;
        n_total++; if (obs[48] !== 32'h0001_0000) $display("FAIL norm_n2_sub0: got %h want 00010000", obs[48]); else n_pass++;
        n_total++; if (obs[51] !== 32'h0000_0201) $display("FAIL norm_n2_sub3: got %h want 00000201", obs[51]); else n_pass++;
        for (int c = 1; c < 200; c++) begin
            n_total++;
            if (od[c] !== (c == DONE_CYC) || ob[c] !== (c <= DONE_CYC))
                $display("FAIL nom_ctl c%0d: done=%b busy=%b want done=%b busy=%b", c, od[c], ob[c], c == DONE_CYC, c <= DONE_CYC);
            else n_pass++;
        end
        for (int i = 0; i < steps.size(); i++) begin
            n_total++;
            if (obs[i+1] !== steps[i])
                $display("FAIL nom_stream step%0d: got %h want %h", i, obs[i+1], steps[i]);
            else n_pass++;
        end
    endtask

    // Runs one pass from idle against the model; hold is forced in [hold_from, hold_from+hold_len),
    // randomly with hold_pct percent, and a stray start may be raised while busy.
    task automatic run_pass(input string tag, input int hold_pct, input int stray_edge,
                            input int hold_from, input int hold_len,
                            input int probe_cyc, output logic [31:0] probe_val, output int done_cyc);
        int          idx;
        int          n;
        int          dones;
        int          e;
        bit          h;
        logic [31:0] exp_inst;
        logic        exp_done;
        n         = steps.size();
        dones     = 0;
        done_cyc  = -1;
        probe_val = 'x;
        start = 1'b1;
        hold  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_total++;
        if (inst !== steps[0] || busy !== 1'b1)
            $display("FAIL %s first: inst=%h busy=%b want inst=%h busy=1", tag, inst, busy, steps[0]);
        else n_pass++;
        idx = 1;
        e   = 1;
        while (idx <= n && e < 2000) begin
            h     = (e >= hold_from && e < hold_from + hold_len) || ($urandom_range(99) < hold_pct);
            hold  = h;
            start = (e == stray_edge) || (hold_pct > 0 && $urandom_range(29) == 0);
            @(posedge clk);
            #1;
            hold  = 1'b0;
            start = 1'b0;
            if (idx < n) begin
                exp_inst = h ? 32'h0 : steps[idx];
                exp_done = 1'b0;
                if (!h) idx++;
            end else begin
                exp_inst = 32'h0;
                exp_done = 1'b1;
                idx++;
            end
            if (e + 1 == probe_cyc) probe_val = inst;
            if (done === 1'b1) begin
                dones++;
                done_cyc = e + 1;
            end
            n_total++;
            if (inst !== exp_inst || done !== exp_done || busy !== 1'b1)
                $display("FAIL %s c%0d: inst=%h done=%b busy=%b want inst=%h done=%b busy=1",
                         tag, e + 1, inst, done, busy, exp_inst, exp_done);
            else n_pass++;
            e++;
        end
        n_total++;
        if (idx <= n) $display("FAIL %s timeout: pass did not complete, step %0d of %0d", tag, idx, n);
        else n_pass++;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_total++;
            if (inst !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || phase !== 4'd0)
                $display("FAIL %s idle_after: inst=%h busy=%b done=%b phase=%0d want 0", tag, inst, busy, done, phase);
            else n_pass++;
        end
        n_total++;
        if (dones !== 1) $display("FAIL %s done_count: got %0d want 1", tag, dones);
        else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] pv;
        int          dc;
        run_pass("hold", 0, -1, 96, 5, 102, pv, dc);
        n_total++;
        if (pv !== 32'h1000_0402) $display("FAIL hold_reissue: got %h want 10000402", pv);
        else n_pass++;
        n_total++;
        if (dc !== DONE_CYC + 5) $display("FAIL hold_done_cycle: got %0d want %0d", dc, DONE_CYC + 5);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] pv;
        int          dc;
        run_pass("stray_start", 0, 94, -1, 0, -1, pv, dc);
        n_total++;
        if (dc !== DONE_CYC) $display("FAIL stray_done_cycle: got %0d want %0d", dc, DONE_CYC);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        hold  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_total++;
        if (inst !== 32'h0 || busy !== 1'b0 || phase !== 4'd0 || done !== 1'b0)
            $display("FAIL reset_mid: inst=%h busy=%b phase=%0d done=%b want 0", inst, busy, phase, done);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_total++;
            if (inst !== 32'h0 || busy !== 1'b0)
                $display("FAIL reset_no_resume: inst=%h busy=%b want 0/0", inst, busy);
            else n_pass++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_total++;
        if (inst !== 32'h0000_0040 || busy !== 1'b1)
            $display("FAIL reset_restart: inst=%h busy=%b want 00000040/1", inst, busy);
        else n_pass++;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] pv;
        int          dc;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(4)) @(posedge clk);
            #1;
            run_pass("random", 25, -1, -1, 0, -1, pv, dc);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_nominal();
        test_hold();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
